// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_tx serial transmitter.
// State encoding and counter sizing live here so top and bench agree.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : piso_pkg

// File: rtl/piso_shreg.sv
// N-bit load/shift register feeding the serial output.
// Shifts zeros in from the far end; the output bit is the end selected by LSB_FIRST.
module piso_shreg #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] din,
  output logic         sout
);

  logic [N-1:0] sr_q;
  logic [N-1:0] sr_d;

  always_comb begin
    // NOTE: default assignment first so every path drives sr_d and no latch is inferred.
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so all flops update from pre-edge values.
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sout = LSB_FIRST ? sr_q[0] : sr_q[N-1];

endmodule : piso_shreg

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word capture, one bit per clock,
// zero-gap streaming when the next word is offered on the last bit of the current one.
module piso_tx
  import piso_pkg::*;
#(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy,
  output logic         done
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sout_valid_q, sout_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          last_bit;
  logic          accept;
  logic          sr_load;
  logic          sr_shift;
  logic [N-1:0]  sr_din;

  assign last_bit   = (state_q == ST_SHIFT) && (cnt_q == LAST);
  assign load_ready = (state_q == ST_IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_din   = d;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          sr_load = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          sr_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end else if (accept) begin
          cnt_d   = '0;
          sr_load = 1'b1;
        end else begin
          // Clearing the register on the way out keeps sout low while idle.
          state_d = ST_IDLE;
          cnt_d   = '0;
          sr_load = 1'b1;
          sr_din  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    sout_valid_d = (state_d == ST_SHIFT);
    busy_d       = (state_d == ST_SHIFT);
    done_d       = (state_d == ST_SHIFT) && (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sout_valid_q <= sout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  piso_shreg #(
    .N         (N),
    .LSB_FIRST (LSB_FIRST)
  ) u_shreg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .sout  (sout)
  );

  assign sout_valid = sout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= LAST);
  a_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_IDLE) |-> (!sout_valid_q && !sout && !done_q));
  a_done_last: assert property (@(posedge clk) disable iff (!rst_n) done_q |-> last_bit);

endmodule : piso_tx

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in, serial-out transmitter with a load-enable parallel capture port and a serial bit-stream output.
- Accepts an N-bit word through a valid/ready handshake and shifts it out one bit per clock, marked by a bit-valid strobe.
- Supports back-to-back words with no idle gap.
- Drives serial links and bit-serial datapaths from parallel register outputs.

Parameters:
- N, 8, word width in bits; legal values are N >= 2.
- LSB_FIRST, 1, bit order: 1 sends d[0] first, 0 sends d[N-1] first.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- d  input  N  parallel word to transmit.
- load_valid  input  1  d is valid and requested for transmission.
- load_ready  output  1  block can accept a word this cycle.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout carries a valid bit this cycle.
- busy  output  1  a word is in flight (state SHIFT).
- done  output  1  one-cycle pulse on the cycle the last bit of a word is on sout.

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock needed):
  - state = IDLE, shift register = 0, bit counter = 0.
  - sout = 0, sout_valid = 0, busy = 0, done = 0, load_ready = 1.
- Handshake:
  - A word is accepted on a rising edge where load_valid && load_ready.
  - d is sampled only on that edge. Changes on d at any other time have no effect.
- load_ready is combinational: 1 in IDLE, and 1 in SHIFT only when the counter is on the last bit (count == N-1). Otherwise 0.
- States:
  - IDLE:
    - Accept moves to SHIFT, loads the shift register with d, and sets count = 0.
    - Otherwise stay in IDLE.
  - SHIFT:
    - Each cycle presents one bit, with sout_valid = 1 and busy = 1.
    - If count < N-1: shift toward the output end, count += 1.
    - If count == N-1 (done = 1):
      - With an accept that cycle: reload with the new d, count = 0, stay in SHIFT. The next cycle carries bit 0 of the new word (zero-gap streaming).
      - Without an accept: go to IDLE.
- Latency:
  - First bit of a word appears on sout in the cycle after acceptance.
  - The word occupies exactly N consecutive sout_valid cycles.
  - Word k+1's first bit directly follows word k's last bit when it is offered in word k's last cycle.
- Outputs are registered: sout, sout_valid, busy and done come from flops, not from d or load_valid.
- In IDLE: sout = 0 and sout_valid = 0.
- Bit order:
  - LSB_FIRST = 1: bit i of the word appears on the i-th valid cycle.
  - LSB_FIRST = 0: bit N-1-i appears on the i-th valid cycle.
- Counter: width $clog2(N); it never exceeds N-1 and never wraps mid-word.
- load_valid high while load_ready is low is ignored; the word is not queued. The source must hold it until load_ready.
- Reset asserted mid-word aborts the word immediately. No partial bits or done follow release. The first cycle after release is IDLE with load_ready = 1.

Decomposition:
- Shared package piso_pkg:
  - State encoding: IDLE = 1'b0, SHIFT = 1'b1.
  - Function computing counter width from N.
- One sub-module: piso_shreg (N-bit shift register with load, shift-enable and direction parameter; async active-low reset).
- FSM and counter stay in piso_tx.

Test Plan:
- Reset then idle, N = 8, rst_n low 3 cycles:
  - During reset: load_ready = 1, all other outputs 0.
  - After release with load_valid = 0 for 10 cycles: outputs unchanged.
- Single word, LSB_FIRST = 1, d = 8'hA5 accepted at cycle t:
  - sout over cycles t+1..t+8 = 1,0,1,0,0,1,0,1, sout_valid = 1.
  - done only at t+8; IDLE at t+9.
- Same word with LSB_FIRST = 0: sout over t+1..t+8 = 1,0,1,0,0,1,0,1 (MSB first), done at t+8.
- Back-to-back, 8'hFF then 8'h00 with load_valid held high:
  - 16 consecutive sout_valid cycles, 8 ones then 8 zeros.
  - done pulses at the 8th and 16th cycles.
  - load_ready high only in IDLE and in the two last-bit cycles.
- Ignored load, then reset abort:
  - Offer 8'h3C mid-word (count = 3); the current word completes unchanged and 8'h3C is not transmitted.
  - Assert rst_n low at count = 4: sout_valid drops to 0 immediately, no done.
  - After release, 8'h81 is accepted and transmitted in full.
- Randomised regression, N = 5, random d and load_valid, 300 cycles:
  - The scoreboard reassembles words from sout/sout_valid and matches every accepted d in order.
  - No sout_valid gaps inside a word.
